// File: rtl/vector_fu_arbiter_pkg.sv
// Shared encodings for the vector FU arbiter: VFU status codes and arbiter state codes.
package vector_fu_arbiter_pkg;

   localparam logic [1:0] VEC_ALU_NOP      = 2'b00;
   localparam logic [1:0] VEC_ALU_WORKING  = 2'b01;
   localparam logic [1:0] VEC_ALU_FINISHED = 2'b10;

   typedef enum logic [1:0] {
      VFU_ARB_IDLE  = 2'b00,
      VFU_ARB_ISSUE = 2'b01,
      VFU_ARB_WAIT  = 2'b10,
      VFU_ARB_RESP  = 2'b11
   } arb_state_e;

endpackage

// File: rtl/vector_fu_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr, wrapping.
module vector_fu_arbiter_rr_picker
   import vector_fu_arbiter_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int REQ_ID_SIZE = 1
) (
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [REQ_ID_SIZE-1:0] rr_ptr,
   output logic [NUM_REQ-1:0]     grant,
   output logic [REQ_ID_SIZE-1:0] grant_idx,
   output logic                   grant_any
);

   // Scan requesters starting at the pointer; the first valid one wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         int                     cand;
         logic [REQ_ID_SIZE-1:0] cidx;
         cand = (int'(rr_ptr) + i) % NUM_REQ;
         cidx = cand[REQ_ID_SIZE-1:0];
         if (!grant_any && req_valid[cidx]) begin
            grant[cidx] = 1'b1;
            grant_idx   = cidx;
            grant_any   = 1'b1;
         end else begin
            grant_any   = grant_any;
         end
      end
   end

endmodule

// File: rtl/vector_fu_arbiter.sv
// Shares one vector function unit between NUM_REQ requesters with round-robin grant.
// Optional macro VFU_ARB_PERF_CNT_EN adds busy-cycle and per-requester grant counters.
module vector_fu_arbiter
   import vector_fu_arbiter_pkg::*;
#(
   parameter int NUM_REQ          = 2,
   parameter int REQ_ID_SIZE      = 1,
   parameter int LEN              = 32,
   parameter int VECTOR_SIZE      = 8,
   parameter int ENTRY_INDEX_SIZE = 3
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      rdy_in,
   input  logic [NUM_REQ-1:0]                        req_valid,
   output logic [NUM_REQ-1:0]                        req_ready,
   input  logic [NUM_REQ*(ENTRY_INDEX_SIZE+1)-1:0]   req_length,
   input  logic [NUM_REQ*VECTOR_SIZE*LEN-1:0]        req_vs1,
   input  logic [NUM_REQ*VECTOR_SIZE*LEN-1:0]        req_vs2,
   input  logic [NUM_REQ*VECTOR_SIZE*LEN-1:0]        req_mask,
   input  logic [NUM_REQ*LEN-1:0]                    req_imm,
   input  logic [NUM_REQ*LEN-1:0]                    req_rs,
   input  logic [NUM_REQ*3-1:0]                      req_alu_signal,
   input  logic [NUM_REQ*2-1:0]                      req_operand_type,
   input  logic [NUM_REQ*6-1:0]                      req_funct6,
   output logic                                      vfu_execute,
   output logic [ENTRY_INDEX_SIZE:0]                 vfu_length,
   output logic [VECTOR_SIZE*LEN-1:0]                vfu_vs1,
   output logic [VECTOR_SIZE*LEN-1:0]                vfu_vs2,
   output logic [VECTOR_SIZE*LEN-1:0]                vfu_mask,
   output logic [LEN-1:0]                            vfu_imm,
   output logic [LEN-1:0]                            vfu_rs,
   output logic [2:0]                                vfu_alu_signal,
   output logic [1:0]                                vfu_operand_type,
   output logic [5:0]                                vfu_funct6,
   input  logic [VECTOR_SIZE*LEN-1:0]                vfu_result,
   input  logic [1:0]                                vfu_status,
   output logic                                      resp_valid,
   input  logic                                      resp_ready,
   output logic [REQ_ID_SIZE-1:0]                    resp_id,
   output logic [VECTOR_SIZE*LEN-1:0]                resp_result,
   output logic                                      busy
`ifdef VFU_ARB_PERF_CNT_EN
  ,output logic [31:0]                               perf_busy_cycles,
   output logic [NUM_REQ*32-1:0]                     perf_grants
`endif
);

   localparam int LW = ENTRY_INDEX_SIZE + 1;
   localparam int VW = VECTOR_SIZE * LEN;

   arb_state_e             state_q, state_d;
   logic [REQ_ID_SIZE-1:0] rr_ptr_q, rr_ptr_d;
   logic [REQ_ID_SIZE-1:0] resp_id_q, resp_id_d;
   logic [VW-1:0]          resp_result_q, resp_result_d;
   logic [LW-1:0]          length_q, length_d;
   logic [VW-1:0]          vs1_q, vs1_d, vs2_q, vs2_d, mask_q, mask_d;
   logic [LEN-1:0]         imm_q, imm_d, rs_q, rs_d;
   logic [2:0]             alu_q, alu_d;
   logic [1:0]             optype_q, optype_d;
   logic [5:0]             funct6_q, funct6_d;

   logic [NUM_REQ-1:0]     grant_s;
   logic [REQ_ID_SIZE-1:0] grant_idx_s;
   logic                   grant_any_s;

   vector_fu_arbiter_rr_picker #(
      .NUM_REQ     (NUM_REQ),
      .REQ_ID_SIZE (REQ_ID_SIZE)
   ) u_picker (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr_q),
      .grant     (grant_s),
      .grant_idx (grant_idx_s),
      .grant_any (grant_any_s)
   );

   // Next-state, operand latching and strobe generation.
   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      resp_id_d     = resp_id_q;
      resp_result_d = resp_result_q;
      length_d      = length_q;
      vs1_d         = vs1_q;
      vs2_d         = vs2_q;
      mask_d        = mask_q;
      imm_d         = imm_q;
      rs_d          = rs_q;
      alu_d         = alu_q;
      optype_d      = optype_q;
      funct6_d      = funct6_q;
      req_ready     = '0;
      vfu_execute   = 1'b0;
      case (state_q)
         VFU_ARB_IDLE: begin
            if (rdy_in && grant_any_s) begin
               req_ready     = grant_s;
               resp_id_d     = grant_idx_s;
               resp_result_d = '0;
               length_d      = req_length[grant_idx_s*LW +: LW];
               vs1_d         = req_vs1[grant_idx_s*VW +: VW];
               vs2_d         = req_vs2[grant_idx_s*VW +: VW];
               mask_d        = req_mask[grant_idx_s*VW +: VW];
               imm_d         = req_imm[grant_idx_s*LEN +: LEN];
               rs_d          = req_rs[grant_idx_s*LEN +: LEN];
               alu_d         = req_alu_signal[grant_idx_s*3 +: 3];
               optype_d      = req_operand_type[grant_idx_s*2 +: 2];
               funct6_d      = req_funct6[grant_idx_s*6 +: 6];
               // Zero-length vectors bypass the VFU with an all-zero result.
               if (req_length[grant_idx_s*LW +: LW] == '0) begin
                  state_d = VFU_ARB_RESP;
               end else begin
                  state_d = VFU_ARB_ISSUE;
               end
            end else begin
               state_d = VFU_ARB_IDLE;
            end
         end
         VFU_ARB_ISSUE: begin
            if (rdy_in && (vfu_status != VEC_ALU_WORKING)) begin
               vfu_execute = 1'b1;
               state_d     = VFU_ARB_WAIT;
            end else begin
               state_d     = VFU_ARB_ISSUE;
            end
         end
         VFU_ARB_WAIT: begin
            if (vfu_status == VEC_ALU_FINISHED) begin
               resp_result_d = vfu_result;
               state_d       = VFU_ARB_RESP;
            end else begin
               state_d       = VFU_ARB_WAIT;
            end
         end
         VFU_ARB_RESP: begin
            if (resp_ready) begin
               rr_ptr_d = (resp_id_q == REQ_ID_SIZE'(NUM_REQ - 1)) ? '0
                                                                  : resp_id_q + REQ_ID_SIZE'(1);
               state_d  = VFU_ARB_IDLE;
            end else begin
               state_d  = VFU_ARB_RESP;
            end
         end
         default: begin
            state_d = VFU_ARB_IDLE;
         end
      endcase
   end

   // State and held-operand registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= VFU_ARB_IDLE;
         rr_ptr_q      <= '0;
         resp_id_q     <= '0;
         resp_result_q <= '0;
         length_q      <= '0;
         vs1_q         <= '0;
         vs2_q         <= '0;
         mask_q        <= '0;
         imm_q         <= '0;
         rs_q          <= '0;
         alu_q         <= 3'd0;
         optype_q      <= 2'd0;
         funct6_q      <= 6'd0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         resp_id_q     <= resp_id_d;
         resp_result_q <= resp_result_d;
         length_q      <= length_d;
         vs1_q         <= vs1_d;
         vs2_q         <= vs2_d;
         mask_q        <= mask_d;
         imm_q         <= imm_d;
         rs_q          <= rs_d;
         alu_q         <= alu_d;
         optype_q      <= optype_d;
         funct6_q      <= funct6_d;
      end
   end

   assign vfu_length       = length_q;
   assign vfu_vs1          = vs1_q;
   assign vfu_vs2          = vs2_q;
   assign vfu_mask         = mask_q;
   assign vfu_imm          = imm_q;
   assign vfu_rs           = rs_q;
   assign vfu_alu_signal   = alu_q;
   assign vfu_operand_type = optype_q;
   assign vfu_funct6       = funct6_q;
   assign resp_valid       = (state_q == VFU_ARB_RESP);
   assign resp_id          = resp_id_q;
   assign resp_result      = resp_result_q;
   assign busy             = (state_q != VFU_ARB_IDLE);

`ifdef VFU_ARB_PERF_CNT_EN
   logic [31:0]         perf_busy_q, perf_busy_d;
   logic [NUM_REQ*32-1:0] perf_grants_q, perf_grants_d;

   // Free-running, wrapping performance counters.
   always_comb begin
      perf_busy_d   = perf_busy_q;
      perf_grants_d = perf_grants_q;
      if (state_q != VFU_ARB_IDLE) begin
         perf_busy_d = perf_busy_q + 32'd1;
      end else begin
         perf_busy_d = perf_busy_q;
      end
      if ((state_q == VFU_ARB_IDLE) && rdy_in && grant_any_s) begin
         perf_grants_d[grant_idx_s*32 +: 32] = perf_grants_q[grant_idx_s*32 +: 32] + 32'd1;
      end else begin
         perf_grants_d = perf_grants_q;
      end
   end

   // Performance counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_busy_q   <= 32'd0;
         perf_grants_q <= '0;
      end else begin
         perf_busy_q   <= perf_busy_d;
         perf_grants_q <= perf_grants_d;
      end
   end

   assign perf_busy_cycles = perf_busy_q;
   assign perf_grants      = perf_grants_q;
`endif

endmodule

// File: tb/tb_vector_fu_arbiter.sv
// Scoreboard bench for vector_fu_arbiter with a small behavioural VFU (LANE_SIZE=2).
module tb_vector_fu_arbiter;

   localparam int NR  = 2;
   localparam int LEN = 32;
   localparam int VS  = 8;
   localparam int LW  = 4;
   localparam int VW  = VS * LEN;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             rdy_in = 1'b0;
   logic [NR-1:0]    req_valid = '0;
   logic [NR-1:0]    req_ready;
   logic [NR*LW-1:0] req_length = '0;
   logic [NR*VW-1:0] req_vs1 = '0, req_vs2 = '0, req_mask = '0;
   logic [NR*LEN-1:0] req_imm = '0, req_rs = '0;
   logic [NR*3-1:0]  req_alu_signal = '0;
   logic [NR*2-1:0]  req_operand_type = '0;
   logic [NR*6-1:0]  req_funct6 = '0;
   logic             vfu_execute;
   logic [LW-1:0]    vfu_length;
   logic [VW-1:0]    vfu_vs1, vfu_vs2, vfu_mask;
   logic [LEN-1:0]   vfu_imm, vfu_rs;
   logic [2:0]       vfu_alu_signal;
   logic [1:0]       vfu_operand_type;
   logic [5:0]       vfu_funct6;
   logic [VW-1:0]    vfu_result;
   logic [1:0]       vfu_status;
   logic             resp_valid;
   logic             resp_ready = 1'b0;
   logic [0:0]       resp_id;
   logic [VW-1:0]    resp_result;
   logic             busy;

   typedef struct packed {
      logic          id;
      logic [VW-1:0] res;
   } sb_t;

   sb_t sb_q[$];
   int  total = 0;
   int  bad = 0;
   int  exec_cnt = 0;

   vector_fu_arbiter dut (
      .clk (clk), .rst (rst), .rdy_in (rdy_in),
      .req_valid (req_valid), .req_ready (req_ready), .req_length (req_length),
      .req_vs1 (req_vs1), .req_vs2 (req_vs2), .req_mask (req_mask),
      .req_imm (req_imm), .req_rs (req_rs), .req_alu_signal (req_alu_signal),
      .req_operand_type (req_operand_type), .req_funct6 (req_funct6),
      .vfu_execute (vfu_execute), .vfu_length (vfu_length), .vfu_vs1 (vfu_vs1),
      .vfu_vs2 (vfu_vs2), .vfu_mask (vfu_mask), .vfu_imm (vfu_imm), .vfu_rs (vfu_rs),
      .vfu_alu_signal (vfu_alu_signal), .vfu_operand_type (vfu_operand_type),
      .vfu_funct6 (vfu_funct6), .vfu_result (vfu_result), .vfu_status (vfu_status),
      .resp_valid (resp_valid), .resp_ready (resp_ready), .resp_id (resp_id),
      .resp_result (resp_result), .busy (busy)
   );

   always #5 clk = ~clk;

   // Behavioural VFU: WORKING for ceil(len/2) cycles after execute, then FINISHED for one.
   logic [1:0]    vst;
   int            vcnt;
   logic [VW-1:0] vres;
   assign vfu_status = vst;
   assign vfu_result = vres;

   function automatic logic [VW-1:0] vfu_calc(input logic [LW-1:0] len, input logic [VW-1:0] x, input logic [VW-1:0] y);
      logic [VW-1:0] r;
      r = '0;
      for (int e = 0; e < VS; e++)
         if (e < int'(len)) r[e*LEN +: LEN] = x[e*LEN +: LEN] + y[e*LEN +: LEN];
      return r;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         vst <= 2'b00; vcnt <= 0; vres <= '0;
      end else if (vfu_execute) begin
         vst <= 2'b01; vcnt <= (int'(vfu_length) + 1) / 2; vres <= vfu_calc(vfu_length, vfu_vs1, vfu_vs2);
      end else if (vst == 2'b01) begin
         if (vcnt <= 1) vst <= 2'b10;
         else vcnt <= vcnt - 1;
      end else begin
         vst <= 2'b00;
      end
   end

   task automatic check_eq(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] want);
      total++;
      if (obs !== want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, want);
      end
   endtask

   function automatic logic [VW-1:0] exp_vec(input int len, input logic [31:0] a, input logic [31:0] b);
      logic [VW-1:0] r;
      r = '0;
      for (int e = 0; e < VS; e++)
         r[e*LEN +: LEN] = (e < len) ? (a + b) : 32'd0;
      return r;
   endfunction

   task automatic push_exp(input logic id, input logic [VW-1:0] res);
      sb_t e;
      e.id = id; e.res = res;
      sb_q.push_back(e);
   endtask

   // Response monitor: pops the scoreboard on every response handshake.
   initial forever begin
      @(negedge clk);
      if (rst && vfu_execute) exec_cnt++;
      if (rst && resp_valid && resp_ready) begin
         if (sb_q.size() == 0) begin
            check_eq("sb_unexpected", VW'(1), VW'(0));
         end else begin
            sb_t e;
            e = sb_q.pop_front();
            check_eq("resp_id", VW'(resp_id), VW'(e.id));
            check_eq("resp_result", resp_result, e.res);
         end
      end
   end

   task automatic tick(); @(posedge clk); #1; endtask
   task automatic samp(); @(negedge clk); #1; endtask

   task automatic set_req(input int i, input logic [LW-1:0] len, input logic [31:0] a, input logic [31:0] b);
      req_length[i*LW +: LW] = len;
      for (int e = 0; e < VS; e++) begin
         req_vs1[i*VW + e*LEN +: LEN] = a;
         req_vs2[i*VW + e*LEN +: LEN] = b;
      end
      req_mask[i*VW +: VW]          = '1;
      req_imm[i*LEN +: LEN]         = 32'(100 + i);
      req_rs[i*LEN +: LEN]          = 32'(200 + i);
      req_alu_signal[i*3 +: 3]      = 3'd0;
      req_operand_type[i*2 +: 2]    = 2'd0;
      req_funct6[i*6 +: 6]          = 6'd0;
   endtask

   task automatic wait_resp_valid(input string tag, output int cyc);
      cyc = 0;
      do begin samp(); cyc++; end while (!resp_valid && cyc < 60);
      if (!resp_valid) check_eq(tag, VW'(0), VW'(1));
   endtask

   task automatic drain(input string tag);
      int g;
      g = 0;
      while ((sb_q.size() != 0 || busy) && g < 300) begin samp(); g++; end
      if (sb_q.size() != 0 || busy) check_eq(tag, VW'(0), VW'(1));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc, e0, n, g;
      logic [VW-1:0] hold;
      // reset state
      samp();
      check_eq("rst_req_ready", VW'(req_ready), VW'(0));
      check_eq("rst_exec", VW'(vfu_execute), VW'(0));
      check_eq("rst_resp_valid", VW'(resp_valid), VW'(0));
      check_eq("rst_busy", VW'(busy), VW'(0));
      check_eq("rst_resp_result", resp_result, VW'(0));
      check_eq("rst_vfu_vs1", vfu_vs1, VW'(0));
      tick(); rst = 1'b1; rdy_in = 1'b1; resp_ready = 1'b1;

      // single request, latency check
      tick(); set_req(0, 4'd8, 32'd1, 32'd1); req_valid = 2'b01;
      push_exp(1'b0, exp_vec(8, 32'd1, 32'd1)); e0 = exec_cnt;
      samp(); check_eq("t1_grant", VW'(req_ready), VW'(2'b01));
      tick(); req_valid = 2'b00;
      samp(); check_eq("t1_exec", VW'(vfu_execute), VW'(1));
      check_eq("t1_vfu_len", VW'(vfu_length), VW'(8));
      check_eq("t1_vfu_imm", VW'(vfu_imm), VW'(100));
      wait_resp_valid("t1_timeout", cyc);
      check_eq("t1_latency", VW'(cyc), VW'(6));
      drain("t1_drain");
      check_eq("t1_exec_cnt", VW'(exec_cnt - e0), VW'(1));

      // zero-length request from req1 (rr_ptr is now 1)
      tick(); set_req(1, 4'd0, 32'd9, 32'd9); req_valid = 2'b10;
      push_exp(1'b1, VW'(0)); e0 = exec_cnt;
      samp(); check_eq("t3_grant", VW'(req_ready), VW'(2'b10));
      tick(); req_valid = 2'b00;
      samp(); check_eq("t3_resp_next", VW'(resp_valid), VW'(1));
      check_eq("t3_result_zero", resp_result, VW'(0));
      check_eq("t3_no_exec", VW'(vfu_execute), VW'(0));
      drain("t3_drain");
      check_eq("t3_exec_cnt", VW'(exec_cnt - e0), VW'(0));

      // both held: grants alternate 0,1,0,1
      tick(); set_req(0, 4'd5, 32'd3, 32'd4); set_req(1, 4'd3, 32'd10, 32'd20); req_valid = 2'b11;
      for (int k = 0; k < 2; k++) begin
         push_exp(1'b0, exp_vec(5, 32'd3, 32'd4));
         push_exp(1'b1, exp_vec(3, 32'd10, 32'd20));
      end
      e0 = exec_cnt;
      samp(); check_eq("t2_first_grant", VW'(req_ready), VW'(2'b01));
      n = 0; g = 0;
      while (n < 4 && g < 400) begin
         samp(); g++;
         if (resp_valid && resp_ready) n++;
      end
      req_valid = 2'b00;
      if (n < 4) check_eq("t2_timeout", VW'(n), VW'(4));
      drain("t2_drain");
      check_eq("t2_exec_cnt", VW'(exec_cnt - e0), VW'(4));

      // backpressure: response held while req1 waits
      tick(); set_req(0, 4'd2, 32'd5, 32'd6); req_valid = 2'b11; resp_ready = 1'b0;
      push_exp(1'b0, exp_vec(2, 32'd5, 32'd6));
      push_exp(1'b1, exp_vec(3, 32'd10, 32'd20)); e0 = exec_cnt;
      samp(); check_eq("t4_grant0", VW'(req_ready), VW'(2'b01));
      tick(); req_valid = 2'b10;
      wait_resp_valid("t4_timeout", cyc);
      hold = exp_vec(2, 32'd5, 32'd6);
      for (int k = 0; k < 5; k++) begin
         check_eq("t4_hold_valid", VW'(resp_valid), VW'(1));
         check_eq("t4_hold_id", VW'(resp_id), VW'(0));
         check_eq("t4_hold_result", resp_result, hold);
         check_eq("t4_no_grant", VW'(req_ready), VW'(0));
         samp();
      end
      tick(); resp_ready = 1'b1;
      samp(); check_eq("t4_no_grant_hs", VW'(req_ready), VW'(0));
      samp(); check_eq("t4_grant_after", VW'(req_ready), VW'(2'b10));
      tick(); req_valid = 2'b00;
      drain("t4_drain");
      check_eq("t4_exec_cnt", VW'(exec_cnt - e0), VW'(2));

      // rdy_in low during WAIT, then low in IDLE
      tick(); set_req(0, 4'd8, 32'd2, 32'd2); req_valid = 2'b01;
      push_exp(1'b0, exp_vec(8, 32'd2, 32'd2)); e0 = exec_cnt;
      samp(); tick(); req_valid = 2'b00;
      samp(); check_eq("t5_exec", VW'(vfu_execute), VW'(1));
      tick(); rdy_in = 1'b0;
      wait_resp_valid("t5_timeout", cyc);
      drain("t5_drain");
      check_eq("t5_exec_cnt", VW'(exec_cnt - e0), VW'(1));
      tick(); req_valid = 2'b11;
      samp(); check_eq("t5_blocked", VW'(req_ready), VW'(0));
      samp(); check_eq("t5_blocked2", VW'(req_ready), VW'(0));
      check_eq("t5_idle", VW'(busy), VW'(0));
      tick(); req_valid = 2'b00; rdy_in = 1'b1;

      // async reset mid-WAIT (rr_ptr is 1 before it)
      tick(); set_req(0, 4'd8, 32'd1, 32'd1); req_valid = 2'b01;
      samp(); tick(); req_valid = 2'b00;
      samp(); samp(); samp();
      check_eq("t6_busy_before", VW'(busy), VW'(1));
      rst = 1'b0; #1;
      check_eq("t6_busy", VW'(busy), VW'(0));
      check_eq("t6_resp_valid", VW'(resp_valid), VW'(0));
      check_eq("t6_req_ready", VW'(req_ready), VW'(0));
      check_eq("t6_exec", VW'(vfu_execute), VW'(0));
      check_eq("t6_vfu_len", VW'(vfu_length), VW'(0));
      check_eq("t6_vfu_vs1", vfu_vs1, VW'(0));
      check_eq("t6_resp_result", resp_result, VW'(0));
      tick(); rst = 1'b1; req_valid = 2'b11;
      samp(); check_eq("t6_rr_ptr0", VW'(req_ready), VW'(2'b01));
      req_valid = 2'b00;
      tick(); set_req(1, 4'd4, 32'd7, 32'd8); req_valid = 2'b10;
      push_exp(1'b1, exp_vec(4, 32'd7, 32'd8));
      samp(); check_eq("t6_grant1", VW'(req_ready), VW'(2'b10));
      tick(); req_valid = 2'b00;
      drain("t6_drain");

      check_eq("sb_empty", VW'(sb_q.size()), VW'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
